// File: rtl/zap_memory_main.sv
// Memory stage of the ZAP pipeline: one req/ack data-bus transaction per load/store,
// store data/byte-enable formatting, load alignment/extension, registered writeback result.
module zap_memory_main #(
  parameter int PHY_REGS = 46
) (
  input  logic                        i_clk,
  input  logic                        i_reset,
  input  logic                        i_clear_from_writeback,
  input  logic                        i_dav_ff,
  input  logic [31:0]                 i_alu_result_ff,
  input  logic [$clog2(PHY_REGS)-1:0] i_destination_index_ff,
  input  logic [31:0]                 i_mem_address_ff,
  input  logic [$clog2(PHY_REGS)-1:0] i_mem_srcdest_index_ff,
  input  logic [31:0]                 i_mem_srcdest_value_ff,
  input  logic                        i_mem_load_ff,
  input  logic                        i_mem_store_ff,
  input  logic                        i_mem_unsigned_byte_enable_ff,
  input  logic                        i_mem_signed_byte_enable_ff,
  input  logic                        i_mem_unsigned_halfword_enable_ff,
  input  logic                        i_mem_signed_halfword_enable_ff,
  input  logic                        i_mem_translate_ff,
  input  logic                        i_abt_ff,
  input  logic                        i_irq_ff,
  input  logic                        i_fiq_ff,
  input  logic                        i_swi_ff,
  output logic                        o_data_req,
  output logic                        o_data_wen,
  output logic [31:0]                 o_data_addr,
  output logic [31:0]                 o_data_wdata,
  output logic [3:0]                  o_data_ben,
  output logic                        o_data_translate,
  input  logic                        i_data_ack,
  input  logic                        i_data_err,
  input  logic [31:0]                 i_data_rdata,
  output logic                        o_data_stall,
  output logic                        o_dav_ff,
  output logic [31:0]                 o_alu_result_ff,
  output logic [$clog2(PHY_REGS)-1:0] o_destination_index_ff,
  output logic                        o_mem_load_ff,
  output logic [31:0]                 o_mem_load_data_ff,
  output logic [$clog2(PHY_REGS)-1:0] o_mem_srcdest_index_ff,
  output logic                        o_dabt_ff,
  output logic                        o_abt_ff,
  output logic                        o_irq_ff,
  output logic                        o_fiq_ff,
  output logic                        o_swi_ff
);

  localparam int IW = $clog2(PHY_REGS);

  typedef enum logic [1:0] {IDLE, ACCESS, DRAIN} state_t;
  state_t state;

  logic          mem_op;
  logic          is_byte, is_half;
  logic [3:0]    ben_fmt;
  logic [31:0]   wdata_fmt;

  // Instruction held while its bus transaction is outstanding.
  logic [31:0]   h_alu_result;
  logic [IW-1:0] h_dest, h_srcdest;
  logic          h_byte, h_half, h_signed;
  logic          h_abt, h_irq, h_fiq, h_swi;

  logic [1:0]    ra;
  logic [7:0]    lb;
  logic [15:0]   lh;
  logic [31:0]   load_fmt;

  assign mem_op  = i_dav_ff & (i_mem_load_ff | i_mem_store_ff);
  assign is_byte = i_mem_unsigned_byte_enable_ff | i_mem_signed_byte_enable_ff;
  assign is_half = ~is_byte & (i_mem_unsigned_halfword_enable_ff | i_mem_signed_halfword_enable_ff);

  always_comb begin
    ben_fmt   = 4'b1111;
    wdata_fmt = i_mem_srcdest_value_ff;
    if (is_byte) begin
      ben_fmt   = 4'b0001 << i_mem_address_ff[1:0];
      wdata_fmt = {4{i_mem_srcdest_value_ff[7:0]}};
    end else if (is_half) begin
      ben_fmt   = i_mem_address_ff[1] ? 4'b1100 : 4'b0011;
      wdata_fmt = {2{i_mem_srcdest_value_ff[15:0]}};
    end
    if (!i_mem_store_ff)
      wdata_fmt = '0;
  end

  // Load alignment keys off the address still held on the bus.
  assign ra = o_data_addr[1:0];

  always_comb begin
    lb = i_data_rdata[7:0];
    case (ra)
      2'd0: lb = i_data_rdata[7:0];
      2'd1: lb = i_data_rdata[15:8];
      2'd2: lb = i_data_rdata[23:16];
      2'd3: lb = i_data_rdata[31:24];
      default: lb = i_data_rdata[7:0];
    endcase
    lh = ra[1] ? i_data_rdata[31:16] : i_data_rdata[15:0];
    if (h_byte)
      load_fmt = h_signed ? {{24{lb[7]}}, lb} : {24'd0, lb};
    else if (h_half)
      load_fmt = h_signed ? {{16{lh[15]}}, lh} : {16'd0, lh};
    else begin
      case (ra)
        2'd0: load_fmt = i_data_rdata;
        2'd1: load_fmt = {i_data_rdata[7:0],  i_data_rdata[31:8]};
        2'd2: load_fmt = {i_data_rdata[15:0], i_data_rdata[31:16]};
        2'd3: load_fmt = {i_data_rdata[23:0], i_data_rdata[31:24]};
        default: load_fmt = i_data_rdata;
      endcase
    end
  end

  always_comb begin
    o_data_stall = 1'b0;
    case (state)
      IDLE:    o_data_stall = mem_op;
      ACCESS:  o_data_stall = ~i_data_ack;
      DRAIN:   o_data_stall = 1'b1;
      default: o_data_stall = 1'b0;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state                  <= IDLE;
      o_data_req             <= 1'b0;
      o_data_wen             <= 1'b0;
      o_data_addr            <= '0;
      o_data_wdata           <= '0;
      o_data_ben             <= '0;
      o_data_translate       <= 1'b0;
      o_dav_ff               <= 1'b0;
      o_alu_result_ff        <= '0;
      o_destination_index_ff <= '0;
      o_mem_load_ff          <= 1'b0;
      o_mem_load_data_ff     <= '0;
      o_mem_srcdest_index_ff <= '0;
      o_dabt_ff              <= 1'b0;
      o_abt_ff               <= 1'b0;
      o_irq_ff               <= 1'b0;
      o_fiq_ff               <= 1'b0;
      o_swi_ff               <= 1'b0;
      h_alu_result           <= '0;
      h_dest                 <= '0;
      h_srcdest              <= '0;
      h_byte                 <= 1'b0;
      h_half                 <= 1'b0;
      h_signed               <= 1'b0;
      h_abt                  <= 1'b0;
      h_irq                  <= 1'b0;
      h_fiq                  <= 1'b0;
      h_swi                  <= 1'b0;
    end else begin
      // Result registers default to a bubble; the cases below override when a result retires.
      o_dav_ff               <= 1'b0;
      o_alu_result_ff        <= '0;
      o_destination_index_ff <= '0;
      o_mem_load_ff          <= 1'b0;
      o_mem_load_data_ff     <= '0;
      o_mem_srcdest_index_ff <= '0;
      o_dabt_ff              <= 1'b0;
      o_abt_ff               <= 1'b0;
      o_irq_ff               <= 1'b0;
      o_fiq_ff               <= 1'b0;
      o_swi_ff               <= 1'b0;
      case (state)
        IDLE: begin
          if (i_clear_from_writeback) begin
            state <= IDLE;
          end else if (mem_op) begin
            state            <= ACCESS;
            o_data_req       <= 1'b1;
            o_data_wen       <= i_mem_store_ff;
            o_data_addr      <= i_mem_address_ff;
            o_data_wdata     <= wdata_fmt;
            o_data_ben       <= ben_fmt;
            o_data_translate <= i_mem_translate_ff;
            h_alu_result     <= i_alu_result_ff;
            h_dest           <= i_destination_index_ff;
            h_srcdest        <= i_mem_srcdest_index_ff;
            h_byte           <= is_byte;
            h_half           <= is_half;
            h_signed         <= i_mem_signed_byte_enable_ff | i_mem_signed_halfword_enable_ff;
            h_abt            <= i_abt_ff;
            h_irq            <= i_irq_ff;
            h_fiq            <= i_fiq_ff;
            h_swi            <= i_swi_ff;
          end else begin
            o_dav_ff               <= i_dav_ff;
            o_alu_result_ff        <= i_alu_result_ff;
            o_destination_index_ff <= i_destination_index_ff;
            o_mem_srcdest_index_ff <= i_mem_srcdest_index_ff;
            o_abt_ff               <= i_abt_ff;
            o_irq_ff               <= i_irq_ff;
            o_fiq_ff               <= i_fiq_ff;
            o_swi_ff               <= i_swi_ff;
          end
        end
        ACCESS: begin
          if (i_data_ack) begin
            state      <= IDLE;
            o_data_req <= 1'b0;
            if (!i_clear_from_writeback) begin
              o_dav_ff               <= 1'b1;
              o_alu_result_ff        <= h_alu_result;
              o_destination_index_ff <= h_dest;
              o_mem_load_ff          <= ~o_data_wen & ~i_data_err;
              o_mem_load_data_ff     <= (~o_data_wen & ~i_data_err) ? load_fmt : '0;
              o_mem_srcdest_index_ff <= h_srcdest;
              o_dabt_ff              <= i_data_err;
              o_abt_ff               <= h_abt;
              o_irq_ff               <= h_irq;
              o_fiq_ff               <= h_fiq;
              o_swi_ff               <= h_swi;
            end
          end else if (i_clear_from_writeback) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (i_data_ack) begin
            state      <= IDLE;
            o_data_req <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_zap_memory_main.sv
// Directed bench for zap_memory_main: pass-through, loads/stores, bus error, flush and async reset.
module tb_zap_memory_main;

  localparam int PHY_REGS = 46;
  localparam int IW = $clog2(PHY_REGS);

  logic          i_clk = 1'b0;
  logic          i_reset;
  logic          i_clear_from_writeback;
  logic          i_dav_ff;
  logic [31:0]   i_alu_result_ff;
  logic [IW-1:0] i_destination_index_ff;
  logic [31:0]   i_mem_address_ff;
  logic [IW-1:0] i_mem_srcdest_index_ff;
  logic [31:0]   i_mem_srcdest_value_ff;
  logic          i_mem_load_ff, i_mem_store_ff;
  logic          i_mem_unsigned_byte_enable_ff, i_mem_signed_byte_enable_ff;
  logic          i_mem_unsigned_halfword_enable_ff, i_mem_signed_halfword_enable_ff;
  logic          i_mem_translate_ff;
  logic          i_abt_ff, i_irq_ff, i_fiq_ff, i_swi_ff;
  logic          o_data_req, o_data_wen;
  logic [31:0]   o_data_addr, o_data_wdata;
  logic [3:0]    o_data_ben;
  logic          o_data_translate;
  logic          i_data_ack, i_data_err;
  logic [31:0]   i_data_rdata;
  logic          o_data_stall, o_dav_ff;
  logic [31:0]   o_alu_result_ff;
  logic [IW-1:0] o_destination_index_ff;
  logic          o_mem_load_ff;
  logic [31:0]   o_mem_load_data_ff;
  logic [IW-1:0] o_mem_srcdest_index_ff;
  logic          o_dabt_ff, o_abt_ff, o_irq_ff, o_fiq_ff, o_swi_ff;

  int unsigned tests = 0;
  int unsigned fails = 0;
  int unsigned stalls;

  zap_memory_main #(.PHY_REGS(PHY_REGS)) dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_clear_from_writeback(i_clear_from_writeback),
    .i_dav_ff(i_dav_ff), .i_alu_result_ff(i_alu_result_ff),
    .i_destination_index_ff(i_destination_index_ff),
    .i_mem_address_ff(i_mem_address_ff),
    .i_mem_srcdest_index_ff(i_mem_srcdest_index_ff),
    .i_mem_srcdest_value_ff(i_mem_srcdest_value_ff),
    .i_mem_load_ff(i_mem_load_ff), .i_mem_store_ff(i_mem_store_ff),
    .i_mem_unsigned_byte_enable_ff(i_mem_unsigned_byte_enable_ff),
    .i_mem_signed_byte_enable_ff(i_mem_signed_byte_enable_ff),
    .i_mem_unsigned_halfword_enable_ff(i_mem_unsigned_halfword_enable_ff),
    .i_mem_signed_halfword_enable_ff(i_mem_signed_halfword_enable_ff),
    .i_mem_translate_ff(i_mem_translate_ff),
    .i_abt_ff(i_abt_ff), .i_irq_ff(i_irq_ff), .i_fiq_ff(i_fiq_ff), .i_swi_ff(i_swi_ff),
    .o_data_req(o_data_req), .o_data_wen(o_data_wen), .o_data_addr(o_data_addr),
    .o_data_wdata(o_data_wdata), .o_data_ben(o_data_ben),
    .o_data_translate(o_data_translate),
    .i_data_ack(i_data_ack), .i_data_err(i_data_err), .i_data_rdata(i_data_rdata),
    .o_data_stall(o_data_stall), .o_dav_ff(o_dav_ff),
    .o_alu_result_ff(o_alu_result_ff),
    .o_destination_index_ff(o_destination_index_ff),
    .o_mem_load_ff(o_mem_load_ff), .o_mem_load_data_ff(o_mem_load_data_ff),
    .o_mem_srcdest_index_ff(o_mem_srcdest_index_ff),
    .o_dabt_ff(o_dabt_ff), .o_abt_ff(o_abt_ff), .o_irq_ff(o_irq_ff),
    .o_fiq_ff(o_fiq_ff), .o_swi_ff(o_swi_ff)
  );

  always #5 i_clk = ~i_clk;

  task automatic tick;
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs;
    i_clear_from_writeback = 1'b0;
    i_dav_ff = 1'b0; i_alu_result_ff = '0; i_destination_index_ff = '0;
    i_mem_address_ff = '0; i_mem_srcdest_index_ff = '0; i_mem_srcdest_value_ff = '0;
    i_mem_load_ff = 1'b0; i_mem_store_ff = 1'b0;
    i_mem_unsigned_byte_enable_ff = 1'b0; i_mem_signed_byte_enable_ff = 1'b0;
    i_mem_unsigned_halfword_enable_ff = 1'b0; i_mem_signed_halfword_enable_ff = 1'b0;
    i_mem_translate_ff = 1'b0;
    i_abt_ff = 1'b0; i_irq_ff = 1'b0; i_fiq_ff = 1'b0; i_swi_ff = 1'b0;
  endtask

  initial begin
    idle_inputs();
    i_data_ack = 1'b0; i_data_err = 1'b0; i_data_rdata = '0;
    i_reset = 1'b1;
    tick(); tick();
    chk("rst_req",   32'(o_data_req), 32'd0);
    chk("rst_dav",   32'(o_dav_ff), 32'd0);
    chk("rst_alu",   o_alu_result_ff, 32'd0);
    chk("rst_stall", 32'(o_data_stall), 32'd0);
    i_reset = 1'b0;
    tick();

    // Non-memory op passes through in one cycle, exception tag included
    i_dav_ff = 1'b1; i_alu_result_ff = 32'h1234_5678; i_destination_index_ff = 6'd5; i_irq_ff = 1'b1;
    #1 chk("alu_stall", 32'(o_data_stall), 32'd0);
    tick();
    chk("alu_result", o_alu_result_ff, 32'h1234_5678);
    chk("alu_dav",    32'(o_dav_ff), 32'd1);
    chk("alu_dest",   32'(o_destination_index_ff), 32'd5);
    chk("alu_irq",    32'(o_irq_ff), 32'd1);
    chk("alu_noreq",  32'(o_data_req), 32'd0);
    idle_inputs();

    // Signed byte load at 0x1003, ack after 3 wait cycles
    i_dav_ff = 1'b1; i_mem_load_ff = 1'b1; i_mem_signed_byte_enable_ff = 1'b1;
    i_mem_address_ff = 32'h0000_1003; i_mem_srcdest_index_ff = 6'd7;
    stalls = 0;
    #1 if (o_data_stall) stalls++;
    tick();
    idle_inputs();
    chk("sb_req",    32'(o_data_req), 32'd1);
    chk("sb_ben",    32'(o_data_ben), 32'b1000);
    chk("sb_wen",    32'(o_data_wen), 32'd0);
    chk("sb_wdata",  o_data_wdata, 32'd0);
    chk("sb_addr",   o_data_addr, 32'h0000_1003);
    chk("sb_bubble", 32'(o_dav_ff), 32'd0);
    for (int i = 0; i < 3; i++) begin
      #1 if (o_data_stall) stalls++;
      tick();
    end
    i_data_ack = 1'b1; i_data_rdata = 32'h80AA_BBCC;
    #1 chk("sb_ack_stall", 32'(o_data_stall), 32'd0);
    tick();
    i_data_ack = 1'b0;
    chk("sb_data",   o_mem_load_data_ff, 32'hFFFF_FF80);
    chk("sb_load",   32'(o_mem_load_ff), 32'd1);
    chk("sb_dav",    32'(o_dav_ff), 32'd1);
    chk("sb_sdidx",  32'(o_mem_srcdest_index_ff), 32'd7);
    chk("sb_reqlo",  32'(o_data_req), 32'd0);
    chk("sb_stalls", stalls, 32'd4);

    // Unsigned halfword store at 0x2002, ack in first ACCESS cycle
    i_dav_ff = 1'b1; i_mem_store_ff = 1'b1; i_mem_unsigned_halfword_enable_ff = 1'b1;
    i_mem_address_ff = 32'h0000_2002; i_mem_srcdest_value_ff = 32'hDEAD_BEEF; i_mem_translate_ff = 1'b1;
    tick();
    idle_inputs();
    chk("sh_wen",   32'(o_data_wen), 32'd1);
    chk("sh_ben",   32'(o_data_ben), 32'b1100);
    chk("sh_wdata", o_data_wdata, 32'hBEEF_BEEF);
    chk("sh_trans", 32'(o_data_translate), 32'd1);
    i_data_ack = 1'b1;
    tick();
    i_data_ack = 1'b0;
    chk("sh_dav",   32'(o_dav_ff), 32'd1);
    chk("sh_load",  32'(o_mem_load_ff), 32'd0);

    // Unsigned byte store at 0x0001
    i_dav_ff = 1'b1; i_mem_store_ff = 1'b1; i_mem_unsigned_byte_enable_ff = 1'b1;
    i_mem_address_ff = 32'h0000_0001; i_mem_srcdest_value_ff = 32'h1234_56A5;
    tick();
    idle_inputs();
    chk("ub_ben",   32'(o_data_ben), 32'b0010);
    chk("ub_wdata", o_data_wdata, 32'hA5A5_A5A5);
    i_data_ack = 1'b1;
    tick();
    i_data_ack = 1'b0;

    // Word load at 0x3001 (rotated), then the same with a bus error
    for (int e = 0; e < 2; e++) begin
      i_dav_ff = 1'b1; i_mem_load_ff = 1'b1; i_mem_address_ff = 32'h0000_3001;
      tick();
      idle_inputs();
      chk("w_ben", 32'(o_data_ben), 32'b1111);
      i_data_ack = 1'b1; i_data_err = (e == 1); i_data_rdata = 32'h1122_3344;
      tick();
      i_data_ack = 1'b0; i_data_err = 1'b0;
      if (e == 0) begin
        chk("w_data", o_mem_load_data_ff, 32'h4411_2233);
        chk("w_dabt", 32'(o_dabt_ff), 32'd0);
      end else begin
        chk("werr_dabt", 32'(o_dabt_ff), 32'd1);
        chk("werr_data", o_mem_load_data_ff, 32'd0);
        chk("werr_load", 32'(o_mem_load_ff), 32'd0);
      end
    end

    // Flush while ACCESS waits: request held through DRAIN, result discarded
    i_dav_ff = 1'b1; i_mem_load_ff = 1'b1; i_mem_address_ff = 32'h0000_4000;
    tick();
    idle_inputs();
    i_clear_from_writeback = 1'b1;
    tick();
    i_clear_from_writeback = 1'b0;
    chk("clr_req",   32'(o_data_req), 32'd1);
    chk("clr_stall", 32'(o_data_stall), 32'd1);
    tick();
    chk("clr_req2",  32'(o_data_req), 32'd1);
    i_data_ack = 1'b1; i_data_rdata = 32'hCAFE_F00D;
    #1 chk("clr_stall_ack", 32'(o_data_stall), 32'd1);
    tick();
    i_data_ack = 1'b0;
    chk("clr_dav",    32'(o_dav_ff), 32'd0);
    chk("clr_reqlo",  32'(o_data_req), 32'd0);
    chk("clr_idle",   32'(o_data_stall), 32'd0);

    // Asynchronous reset in the middle of ACCESS
    i_dav_ff = 1'b1; i_mem_store_ff = 1'b1; i_mem_address_ff = 32'h0000_5004;
    i_mem_srcdest_value_ff = 32'h5555_AAAA;
    tick();
    idle_inputs();
    chk("ar_req_before", 32'(o_data_req), 32'd1);
    #1 i_reset = 1'b1;
    #1;
    chk("ar_req",   32'(o_data_req), 32'd0);
    chk("ar_addr",  o_data_addr, 32'd0);
    chk("ar_stall", 32'(o_data_stall), 32'd0);
    i_data_ack = 1'b1;
    tick();
    i_data_ack = 1'b0;
    i_reset = 1'b0;
    tick();
    chk("ar_dav_after", 32'(o_dav_ff), 32'd0);
    chk("ar_req_after", 32'(o_data_req), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/zap_memory_main.md
Name: zap_memory_main

Overview:
- Memory stage behind the ALU stage. Consumes the registered ALU/memory-control outputs and runs one data-bus transaction per load/store. Transactions use a req/ack handshake.
- Formats store data and byte enables; aligns and extends load data.
- Stalls the upstream pipeline while a transaction is outstanding.
- Presents a registered result to writeback.

Parameters:
PHY_REGS, 46, number of physical registers; index width is $clog2(PHY_REGS).

Ports:
i_clk  in  1  ZAP clock.
i_reset  in  1  asynchronous active-high reset.
i_clear_from_writeback  in  1  pipeline flush.
i_dav_ff  in  1  instruction valid and condition passed.
i_alu_result_ff  in  32  ALU result.
i_destination_index_ff  in  $clog2(PHY_REGS)  ALU destination register.
i_mem_address_ff  in  32  memory address.
i_mem_srcdest_index_ff  in  $clog2(PHY_REGS)  load destination / store source register.
i_mem_srcdest_value_ff  in  32  store value.
i_mem_load_ff, i_mem_store_ff  in  1 each  access type.
i_mem_unsigned_byte_enable_ff, i_mem_signed_byte_enable_ff, i_mem_unsigned_halfword_enable_ff, i_mem_signed_halfword_enable_ff  in  1 each  access size; all low means word.
i_mem_translate_ff  in  1  user-mode translation request.
i_abt_ff, i_irq_ff, i_fiq_ff, i_swi_ff  in  1 each  exception tags.
o_data_req  out  1  bus request.
o_data_wen  out  1  1 = write.
o_data_addr  out  32  bus address.
o_data_wdata  out  32  formatted store data.
o_data_ben  out  4  byte enables.
o_data_translate  out  1  translation request.
i_data_ack  in  1  transfer complete.
i_data_err  in  1  bus error; qualifies i_data_ack.
i_data_rdata  in  32  read data, valid with i_data_ack.
o_data_stall  out  1  upstream hold.
o_dav_ff  out  1  result valid.
o_alu_result_ff  out  32  ALU result.
o_destination_index_ff  out  $clog2(PHY_REGS)  ALU destination register.
o_mem_load_ff  out  1  load result valid.
o_mem_load_data_ff  out  32  formatted load data.
o_mem_srcdest_index_ff  out  $clog2(PHY_REGS)  load destination register.
o_dabt_ff  out  1  data abort.
o_abt_ff, o_irq_ff, o_fiq_ff, o_swi_ff  out  1 each  exception tags, passed through.

Behaviour:
- Reset (async): every output 0; FSM to IDLE. Reset mid-transaction drops o_data_req immediately; any later ack is ignored.
- mem_op = i_dav_ff & (i_mem_load_ff | i_mem_store_ff).
- FSM states: IDLE, ACCESS, DRAIN.
- IDLE, no mem_op: output registers load inputs every cycle (1-cycle pass-through); o_mem_load_ff=0; o_dabt_ff=0.
- IDLE, mem_op:
  - o_data_stall=1 combinationally.
  - Next edge registers bus fields and sets o_data_req=1; go to ACCESS.
  - Output registers load a bubble (o_dav_ff=0, all flags 0).
- ACCESS:
  - Bus fields and req held stable.
  - o_data_stall = ~i_data_ack.
  - On ack edge: o_data_req=0; outputs take the held instruction's values; go to IDLE.
  - On ack with err=1: o_dabt_ff=1, o_mem_load_ff=0, o_mem_load_data_ff=0.
  - Minimum memory-op latency is 2 cycles (ack in the first ACCESS cycle).
- DRAIN:
  - Entered from ACCESS on clear without ack.
  - Req held; o_data_stall=1; ack result discarded; then IDLE.
- Clear (i_clear_from_writeback):
  - Highest priority below reset; output registers zeroed.
  - IDLE stays IDLE and no request is issued.
  - ACCESS with same-cycle ack goes to IDLE, result discarded.
  - ACCESS without ack goes to DRAIN.
- Store byte enables and data (a=address[1:0]):
  - byte: ben=1<<a, wdata={4{v[7:0]}}.
  - halfword: ben = a[1] ? 4'b1100 : 4'b0011, wdata={2{v[15:0]}}; a[0] ignored.
  - word: ben=4'b1111, wdata=v.
- Loads: ben computed as for stores; wdata=0.
- Load formatting from rdata:
  - byte = rdata[8a+7:8a], zero- or sign-extended per the enables.
  - halfword = rdata[16a[1]+15:16a[1]], zero- or sign-extended.
  - word = rdata rotated right by 8a.
- o_data_addr = full address. o_data_translate = i_mem_translate_ff. o_data_wen = store.
- Store completion: o_dav_ff=1, o_mem_load_ff=0.

Test Plan:
- Reset: assert i_reset mid-ACCESS, no clock edge -> o_data_req=0 at once; all outputs 0; FSM IDLE.
- Non-mem op: ALU result 0x1234_5678, dav=1 -> next cycle o_alu_result_ff=0x12345678, o_dav_ff=1, o_data_stall=0, no req.
- Signed byte load: addr 0x1003, rdata 0x80AA_BBCC, ack after 3 wait cycles -> ben=1000, o_mem_load_data_ff=0xFFFF_FF80; stall high 4 cycles total.
- Unsigned halfword store: addr 0x2002, value 0xDEAD_BEEF -> wen=1, ben=1100, wdata=0xBEEF_BEEF.
- Word load, addr 0x3001, rdata 0x1122_3344 -> load data 0x4411_2233. Repeat with err=1 -> o_dabt_ff=1, load data 0.
- Clear in ACCESS without ack: req held, stall=1 until ack; next cycle o_dav_ff=0, FSM IDLE.
